// File: rtl/hazard_stall_controller_if.sv
// Hazard/stall controller bus: ID/EX hazard inputs, mult/div handshake
// and the pipeline-register control outputs.
// master: the pipeline side that drives the hazard inputs.
// slave:  the controller.
interface hazard_stall_controller_if;
  logic       ID_EX_MemRead_i;
  logic [4:0] ID_EX_RT_i;
  logic [4:0] IF_ID_RS_i;
  logic [4:0] IF_ID_RT_i;
  logic       IF_ID_UsesRT_i;
  logic       Branch_taken_i;
  logic       ID_MD_start_i;
  logic       ID_MD_read_i;
  logic       MD_start_o;
  logic       MD_busy_o;
  logic       PC_Write_o;
  logic       IF_ID_Write_o;
  logic       ID_EX_Flush_o;
  logic       IF_ID_Flush_o;

  modport master (
    output ID_EX_MemRead_i, ID_EX_RT_i, IF_ID_RS_i, IF_ID_RT_i,
           IF_ID_UsesRT_i, Branch_taken_i, ID_MD_start_i, ID_MD_read_i,
    input  MD_start_o, MD_busy_o, PC_Write_o, IF_ID_Write_o,
           ID_EX_Flush_o, IF_ID_Flush_o
  );

  modport slave (
    input  ID_EX_MemRead_i, ID_EX_RT_i, IF_ID_RS_i, IF_ID_RT_i,
           IF_ID_UsesRT_i, Branch_taken_i, ID_MD_start_i, ID_MD_read_i,
    output MD_start_o, MD_busy_o, PC_Write_o, IF_ID_Write_o,
           ID_EX_Flush_o, IF_ID_Flush_o
  );
endinterface

// File: rtl/hazard_stall_controller.sv
// Hazard/stall controller: load-use detection, mult/div issue and busy
// tracking, stall vs. taken-branch flush arbitration.
// Optional macro STALL_PERF_EN adds a saturating 32-bit stall-cycle
// counter on output Stall_cycles_o.
module hazard_stall_controller #(
  parameter int MD_LATENCY = 8,
  parameter int CNT_W      = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  hazard_stall_controller_if.slave bus
`ifdef STALL_PERF_EN
  ,
  output logic [31:0]              Stall_cycles_o
`endif
);

  localparam logic [CNT_W-1:0] LAT_M1 = CNT_W'(MD_LATENCY - 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             busy_q;

  logic load_use;
  logic md_hazard;
  logic stall;
  logic md_issue;

  // Hazard detection: load result not forwardable in time, or HI/LO busy
  always_comb begin
    load_use  = bus.ID_EX_MemRead_i && (bus.ID_EX_RT_i != 5'd0) &&
                ((bus.ID_EX_RT_i == bus.IF_ID_RS_i) ||
                 (bus.IF_ID_UsesRT_i && (bus.ID_EX_RT_i == bus.IF_ID_RT_i)));
    md_hazard = (state_q == RUN) && (bus.ID_MD_start_i || bus.ID_MD_read_i);
    stall     = load_use || md_hazard;
    // A mult held back by load-use retries on the following cycle
    md_issue  = (state_q == IDLE) && bus.ID_MD_start_i && !load_use;
  end

  // Pipeline controls; stall wins over branch flush so the branch re-resolves
  always_comb begin
    bus.PC_Write_o    = 1'b1;
    bus.IF_ID_Write_o = 1'b1;
    bus.ID_EX_Flush_o = 1'b0;
    bus.IF_ID_Flush_o = 1'b0;
    bus.MD_start_o    = 1'b0;
    if (!rst_i) begin
      if (stall) begin
        bus.PC_Write_o    = 1'b0;
        bus.IF_ID_Write_o = 1'b0;
        bus.ID_EX_Flush_o = 1'b1;
      end else begin
        bus.IF_ID_Flush_o = bus.Branch_taken_i;
      end
      bus.MD_start_o = md_issue;
    end
  end

  assign bus.MD_busy_o = busy_q;

  // Mult/div busy-window FSM: counter runs MD_LATENCY-1 down to 0 in RUN
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (md_issue) begin
            state_q <= RUN;
            cnt_q   <= LAT_M1;
            busy_q  <= 1'b1;
          end
        end
        RUN: begin
          if (cnt_q == '0) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
          cnt_q   <= '0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

`ifdef STALL_PERF_EN
  logic [31:0] stall_cnt_q;
  logic [31:0] stall_cnt_d;

  // Next stall count: saturates instead of wrapping
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (!bus.PC_Write_o && (stall_cnt_q != 32'hFFFF_FFFF))
      stall_cnt_d = stall_cnt_q + 32'd1;
  end

  // Stall-cycle counter register
  always_ff @(posedge clk_i) begin
    if (rst_i) stall_cnt_q <= '0;
    else       stall_cnt_q <= stall_cnt_d;
  end

  assign Stall_cycles_o = stall_cnt_q;
`endif

endmodule

// File: doc/hazard_stall_controller.md
Name: hazard_stall_controller

Overview:
- Sequences the pipeline around hazards the forwarding path cannot resolve.
- Detects load-use hazards in ID and issues mult/div instructions to the multi-cycle HI/LO unit.
- Tracks the HI/LO unit's busy window and stalls dependent or back-to-back mult/div/mfhi/mflo in ID.
- Arbitrates stall against taken-branch flush; drives PC, IF/ID and ID/EX pipeline-register controls.

Parameters:
- MD_LATENCY, 8, busy cycles of the mult/div unit after issue; legal range 2..2**CNT_W.
- CNT_W, 4, width of the internal busy down-counter.

Ports:
- clk_i  in  1  clock, rising edge
- rst_i  in  1  synchronous reset, active-high
- ID_EX_MemRead_i  in  1  EX-stage instruction is a load
- ID_EX_RT_i  in  5  load destination register in EX
- IF_ID_RS_i  in  5  rs of ID-stage instruction
- IF_ID_RT_i  in  5  rt of ID-stage instruction
- IF_ID_UsesRT_i  in  1  ID instruction reads rt as a source
- Branch_taken_i  in  1  ID-stage branch/jump resolved taken
- ID_MD_start_i  in  1  ID instruction is mult/multu/div/divu
- ID_MD_read_i  in  1  ID instruction is mfhi/mflo
- MD_start_o  out  1  one-cycle issue pulse to mult/div unit
- MD_busy_o  out  1  mult/div unit running (registered)
- PC_Write_o  out  1  0 = hold PC
- IF_ID_Write_o  out  1  0 = hold IF/ID register
- ID_EX_Flush_o  out  1  1 = insert bubble into ID/EX
- IF_ID_Flush_o  out  1  1 = squash IF/ID (taken branch)

Behaviour:
- Reset:
  - State IDLE, counter 0, MD_busy_o=0.
  - While rst_i=1: PC_Write_o=1, IF_ID_Write_o=1, ID_EX_Flush_o=0, IF_ID_Flush_o=0, MD_start_o=0.
  - Reset mid-RUN abandons the operation; MD_busy_o=0 the cycle after the reset edge.
- load_use (combinational):
  - Condition: ID_EX_MemRead_i & ID_EX_RT_i!=0 & (ID_EX_RT_i==IF_ID_RS_i | (IF_ID_UsesRT_i & ID_EX_RT_i==IF_ID_RT_i)).
- md_hazard (combinational): state==RUN & (ID_MD_start_i | ID_MD_read_i).
- stall = load_use | md_hazard. When stall=1:
  - PC_Write_o=0, IF_ID_Write_o=0, ID_EX_Flush_o=1.
  - IF_ID_Flush_o=0: stall beats branch flush; the branch re-resolves next cycle.
- When stall=0: PC_Write_o=1, IF_ID_Write_o=1, ID_EX_Flush_o=0, IF_ID_Flush_o=Branch_taken_i.
- FSM states:
  - IDLE: if ID_MD_start_i & !load_use, then MD_start_o=1 (same cycle, combinational), counter<=MD_LATENCY-1, state<=RUN.
  - IDLE with load_use: no issue; the mult retries next cycle.
  - RUN: MD_busy_o=1 and MD_start_o=0. Counter decrements each cycle; when counter==0, state<=IDLE.
- Timing: issue at cycle T, then MD_busy_o=1 for T+1..T+MD_LATENCY.
- A waiting mflo/mult stalls through T+MD_LATENCY. At T+MD_LATENCY+1 it proceeds; a waiting mult issues then.
- No issue in the last busy cycle.
- Independent instructions (no md_hazard, no load_use) flow unstalled during RUN.
- Counter never underflows; no wrap.

Optional Feature:
- Macro STALL_PERF_EN.
- Defined:
  - Adds output Stall_cycles_o, 32 bits, reset 0.
  - Increments each cycle PC_Write_o=0 and rst_i=0.
  - Saturates at 32'hFFFF_FFFF.
- Undefined: port and counter absent; all other behaviour identical.

Test Plan:
- Load-use on rs: ID_EX_MemRead_i=1, ID_EX_RT_i=5, IF_ID_RS_i=5 -> exactly one cycle PC_Write_o=0, IF_ID_Write_o=0, ID_EX_Flush_o=1. Next cycle with MemRead_i=0 -> all normal.
- Load to $0, or rt match with IF_ID_UsesRT_i=0: RT=0/RS=0; RT=7, IF_ID_RT_i=7, UsesRT=0 -> no stall.
- Mult then mflo, MD_LATENCY=8: mult issues at T with MD_start_o=1.
  - mflo in ID from T+1 -> stalled T+1..T+8, MD_busy_o=1 T+1..T+8.
  - mflo proceeds at T+9.
- Back-to-back mult: second mult stalled T+1..T+8 -> MD_start_o=1 at T+9, busy T+10..T+17.
- Stall vs branch, and load-use vs mult issue:
  - load_use with Branch_taken_i=1 -> IF_ID_Flush_o=0; next cycle no hazard -> IF_ID_Flush_o=1.
  - mult with load_use -> MD_start_o=0, issues one cycle later.
- Reset at T+3 of RUN: MD_busy_o=0 at T+4, state IDLE, outputs at reset values. With STALL_PERF_EN: Stall_cycles_o=0.
